// File: rtl/expression_sequencer.sv
// Launches expressions 0..NUM_EXPR-1 through term_accumulator, buffers the results and writes them back once per iteration.
// The start pulse appears one cycle after an accepted run_start. There is no backpressure: each result must arrive within TIMEOUT_CYCLES.
module expression_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_EXPR       = 3,
  parameter int NUM_STATE_VAR  = 9,
  parameter int WB_BASE        = 0,
  parameter int ITER_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             run_start,
  input  logic [ITER_WIDTH-1:0]            num_iterations,
  output logic                             term_accumulator_start,
  output logic [1:0]                       expression_index,
  input  logic [DATA_WIDTH-1:0]            acc_output_value,
  input  logic                             acc_output_ready,
  output logic                             mem_state_var_wr_en,
  output logic [$clog2(NUM_STATE_VAR)-1:0] mem_state_var_wr_addr,
  output logic [DATA_WIDTH-1:0]            mem_state_var_wr_data,
  output logic [ITER_WIDTH-1:0]            iteration_count,
  output logic                             busy,
  output logic                             done,
  output logic                             timeout_error
);
  localparam int         AW        = $clog2(NUM_STATE_VAR);
  localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [1:0] LAST_EXPR = 2'(NUM_EXPR - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_RESULT, S_GAP, S_WRITEBACK, S_NEXT_ITER, S_DONE, S_ERROR
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              expr_q, expr_d;
  logic [1:0]              wb_q, wb_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [ITER_WIDTH-1:0]   num_iter_q, num_iter_d;
  logic [ITER_WIDTH-1:0]   iter_q, iter_d;
  logic [DATA_WIDTH-1:0]   res_buf_q [4];
  logic [DATA_WIDTH-1:0]   res_buf_d [4];
  logic                    tmo_err_q, tmo_err_d;
  logic                    start_q, start_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    wr_en_q, wr_en_d;
  logic [AW-1:0]           wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;

  always_comb begin
    state_d    = state_q;
    expr_d     = expr_q;
    wb_d       = wb_q;
    tmo_d      = tmo_q;
    num_iter_d = num_iter_q;
    iter_d     = iter_q;
    res_buf_d  = res_buf_q;
    tmo_err_d  = tmo_err_q;

    case (state_q)
      S_IDLE: begin
        if (run_start) begin
          num_iter_d = num_iterations;
          iter_d     = '0;
          tmo_err_d  = 1'b0;
          expr_d     = 2'd0;
          state_d    = (num_iterations == '0) ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tmo_d   = '0;
        state_d = S_WAIT_RESULT;
      end
      S_WAIT_RESULT: begin
        if (acc_output_ready) begin
          res_buf_d[expr_q] = acc_output_value;
          state_d           = S_GAP;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
            tmo_err_d = 1'b1;
            state_d   = S_ERROR;
          end
        end
      end
      // Idle cycle lets the accumulator settle before the next launch.
      S_GAP: begin
        if (expr_q != LAST_EXPR) begin
          expr_d  = expr_q + 2'd1;
          state_d = S_LAUNCH;
        end else begin
          wb_d    = 2'd0;
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        if (wb_q == LAST_EXPR) state_d = S_NEXT_ITER;
        else                   wb_d    = wb_q + 2'd1;
      end
      S_NEXT_ITER: begin
        if (iter_q != '1) iter_d = iter_q + ITER_WIDTH'(1);
        if (iter_d == num_iter_q) begin
          state_d = S_DONE;
        end else begin
          expr_d  = 2'd0;
          state_d = S_LAUNCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    start_d   = (state_d == S_LAUNCH);
    done_d    = (state_d == S_DONE);
    busy_d    = !(state_d inside {S_IDLE, S_DONE, S_ERROR});
    wr_en_d   = (state_d == S_WRITEBACK);
    wr_addr_d = wr_en_d ? (AW'(WB_BASE) + AW'(wb_d)) : '0;
    wr_data_d = wr_en_d ? res_buf_q[wb_d] : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      expr_q     <= '0;
      wb_q       <= '0;
      tmo_q      <= '0;
      num_iter_q <= '0;
      iter_q     <= '0;
      tmo_err_q  <= 1'b0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < 4; i++) res_buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      expr_q     <= expr_d;
      wb_q       <= wb_d;
      tmo_q      <= tmo_d;
      num_iter_q <= num_iter_d;
      iter_q     <= iter_d;
      tmo_err_q  <= tmo_err_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      res_buf_q  <= res_buf_d;
    end
  end

  assign term_accumulator_start = start_q;
  assign expression_index       = expr_q;
  assign mem_state_var_wr_en    = wr_en_q;
  assign mem_state_var_wr_addr  = wr_addr_q;
  assign mem_state_var_wr_data  = wr_data_q;
  assign iteration_count        = iter_q;
  assign busy                   = busy_q;
  assign done                   = done_q;
  assign timeout_error          = tmo_err_q;
endmodule

// File: tb/tb_expression_sequencer.sv
// Directed bench for expression_sequencer: run-level vector table plus hand sequences for reset and spurious inputs.
// A small accumulator model answers LAT cycles after each start; a negedge monitor checks index, write order and data.
module tb_expression_sequencer;
  localparam int DW  = 32;
  localparam int NE  = 3;
  localparam int NSV = 9;
  localparam int WB  = 0;
  localparam int IW  = 16;
  localparam int TO  = 20;
  localparam int LAT = 5;
  localparam int AW  = $clog2(NSV);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          run_start = 1'b0;
  logic [IW-1:0] num_iterations = '0;
  logic          term_accumulator_start;
  logic [1:0]    expression_index;
  logic [DW-1:0] acc_output_value = '0;
  logic          acc_output_ready = 1'b0;
  logic          mem_state_var_wr_en;
  logic [AW-1:0] mem_state_var_wr_addr;
  logic [DW-1:0] mem_state_var_wr_data;
  logic [IW-1:0] iteration_count;
  logic          busy;
  logic          done;
  logic          timeout_error;

  int n_checks = 0;
  int n_errors = 0;

  // Written only by the stimulus process.
  int mute_idx = -1;
  int run_base_start = 0;
  int run_base_wr = 0;
  int spur_req_n = 0;

  // Written only by the model/monitor process.
  int            start_cnt = 0;
  int            wr_cnt = 0;
  int            mon_bad = 0;
  int            spur_done_n = 0;
  int            ans_cnt = 0;
  int            cnt = 0;
  bit            pending = 1'b0;
  bit            prev_wr = 1'b0;
  logic [1:0]    pidx = '0;
  logic [DW-1:0] last_ans [4];

  expression_sequencer #(
    .DATA_WIDTH(DW), .NUM_EXPR(NE), .NUM_STATE_VAR(NSV), .WB_BASE(WB),
    .ITER_WIDTH(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .run_start(run_start), .num_iterations(num_iterations),
    .term_accumulator_start(term_accumulator_start), .expression_index(expression_index),
    .acc_output_value(acc_output_value), .acc_output_ready(acc_output_ready),
    .mem_state_var_wr_en(mem_state_var_wr_en), .mem_state_var_wr_addr(mem_state_var_wr_addr),
    .mem_state_var_wr_data(mem_state_var_wr_data), .iteration_count(iteration_count),
    .busy(busy), .done(done), .timeout_error(timeout_error)
  );

  always #5 clock = ~clock;

  // Accumulator model and monitor; drives and samples on the falling edge.
  always @(negedge clock) begin : model
    int pos;
    acc_output_ready = 1'b0;
    if (spur_req_n != spur_done_n) begin
      spur_done_n      = spur_req_n;
      acc_output_ready = 1'b1;
      acc_output_value = 32'hDEAD_BEEF;
    end
    if (pending) begin
      if (cnt == 0) begin
        pending = 1'b0;
        if (int'(pidx) != mute_idx) begin
          if (expression_index != pidx) begin
            mon_bad++;
            $display("  monitor: index moved before capture got %0d want %0d", expression_index, pidx);
          end
          ans_cnt++;
          acc_output_value = {8'hA0 + {6'd0, pidx}, 8'h00, 16'(ans_cnt)};
          last_ans[pidx]   = acc_output_value;
          acc_output_ready = 1'b1;
        end
      end else begin
        cnt--;
      end
    end
    if (term_accumulator_start) begin
      if (int'(expression_index) != (start_cnt - run_base_start) % NE) begin
        mon_bad++;
        $display("  monitor: start index got %0d want %0d", expression_index, (start_cnt - run_base_start) % NE);
      end
      start_cnt++;
      pending = 1'b1;
      cnt     = LAT - 1;
      pidx    = expression_index;
    end
    if (mem_state_var_wr_en) begin
      pos = (wr_cnt - run_base_wr) % NE;
      if (int'(mem_state_var_wr_addr) != pos + WB) begin
        mon_bad++;
        $display("  monitor: write addr got %0d want %0d", mem_state_var_wr_addr, pos + WB);
      end
      if (mem_state_var_wr_data != last_ans[pos]) begin
        mon_bad++;
        $display("  monitor: write data got %h want %h", mem_state_var_wr_data, last_ans[pos]);
      end
      if (pos != 0 && !prev_wr) begin
        mon_bad++;
        $display("  monitor: writes not on consecutive cycles at position %0d", pos);
      end
      wr_cnt++;
    end
    prev_wr = mem_state_var_wr_en;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic begin_run(input int n);
    @(negedge clock);
    num_iterations = IW'(n);
    run_start      = 1'b1;
    run_base_start = start_cnt;
    run_base_wr    = wr_cnt;
    @(negedge clock);
    run_start = 1'b0;
  endtask

  task automatic wait_end(output bit ended, output bit saw_done, output int cycles);
    ended = 1'b0; saw_done = 1'b0; cycles = 0;
    while (!ended && cycles < 3000) begin
      if (done || timeout_error) begin
        ended    = 1'b1;
        saw_done = done;
      end else begin
        @(negedge clock);
        cycles++;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"},   int'(term_accumulator_start), 0);
    chk({tag, "_index"},   int'(expression_index), 0);
    chk({tag, "_wr_en"},   int'(mem_state_var_wr_en), 0);
    chk({tag, "_wr_addr"}, int'(mem_state_var_wr_addr), 0);
    chk({tag, "_wr_data"}, int'(mem_state_var_wr_data), 0);
    chk({tag, "_iter"},    int'(iteration_count), 0);
    chk({tag, "_busy"},    int'(busy), 0);
    chk({tag, "_done"},    int'(done), 0);
    chk({tag, "_tmo"},     int'(timeout_error), 0);
  endtask

  typedef struct {
    int niter; int mute; int cycles; int starts; int writes; int iter; int tmo; int saw_done;
  } vec_t;

  initial begin
    vec_t vecs [7];
    bit   ended, saw_done, found;
    int   cycles, s0, w0, b0;

    // niter, muted expr, cycles to done/error, starts, writes, iteration_count, timeout_error, done
    vecs[0] = '{1, -1,  25,  3,  3, 1, 0, 1};
    vecs[1] = '{0, -1,   0,  0,  0, 0, 0, 1};
    vecs[2] = '{4, -1, 100, 12, 12, 4, 0, 1};
    vecs[3] = '{1,  1,  28,  2,  0, 0, 1, 0};
    vecs[4] = '{2, -1,  50,  6,  6, 2, 0, 1};
    vecs[5] = '{3,  2,  35,  3,  0, 0, 1, 0};
    vecs[6] = '{1, -1,  25,  3,  3, 1, 0, 1};

    repeat (3) @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      mute_idx = vecs[v].mute;
      s0 = start_cnt; w0 = wr_cnt; b0 = mon_bad;
      begin_run(vecs[v].niter);
      chk($sformatf("v%0d_busy_after_start", v), int'(busy), int'(vecs[v].niter != 0));
      wait_end(ended, saw_done, cycles);
      chk($sformatf("v%0d_ended", v), int'(ended), 1);
      chk($sformatf("v%0d_cycles", v), cycles, vecs[v].cycles);
      chk($sformatf("v%0d_done", v), int'(saw_done), vecs[v].saw_done);
      @(negedge clock);
      chk($sformatf("v%0d_done_one_cycle", v), int'(done), 0);
      chk($sformatf("v%0d_busy_end", v), int'(busy), 0);
      repeat (3) @(negedge clock);
      chk($sformatf("v%0d_starts", v), start_cnt - s0, vecs[v].starts);
      chk($sformatf("v%0d_writes", v), wr_cnt - w0, vecs[v].writes);
      chk($sformatf("v%0d_iter_count", v), int'(iteration_count), vecs[v].iter);
      chk($sformatf("v%0d_tmo", v), int'(timeout_error), vecs[v].tmo);
      chk($sformatf("v%0d_monitor", v), mon_bad - b0, 0);
    end

    // Reset in the middle of writeback, right after the first word.
    mute_idx = -1;
    begin_run(2);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mem_state_var_wr_en) found = 1'b1;
      else @(negedge clock);
    end
    chk("rst_saw_first_write", int'(found), 1);
    reset = 1'b1;
    @(negedge clock);
    chk_all_zero("midrst");
    reset = 1'b0;
    repeat (60) @(negedge clock);
    chk("rst_writes_total", wr_cnt - run_base_wr, 1);
    chk("rst_busy_after", int'(busy), 0);

    // Spurious ready while idle.
    s0 = start_cnt;
    @(negedge clock);
    #1 spur_req_n++;
    repeat (4) @(negedge clock);
    chk("idle_spur_starts", start_cnt - s0, 0);
    chk("idle_spur_busy", int'(busy), 0);

    // Spurious ready in GAP and run_start mid-run; the run must finish unchanged.
    s0 = start_cnt; w0 = wr_cnt; b0 = mon_bad;
    begin_run(1);
    repeat (5) @(negedge clock);
    #1 spur_req_n++;
    repeat (5) @(negedge clock);
    num_iterations = IW'(5);
    run_start = 1'b1;
    @(negedge clock);
    run_start = 1'b0;
    wait_end(ended, saw_done, cycles);
    chk("mid_ended", int'(ended), 1);
    chk("mid_cycles", 11 + cycles, 25);
    chk("mid_done", int'(saw_done), 1);
    repeat (3) @(negedge clock);
    chk("mid_starts", start_cnt - s0, 3);
    chk("mid_writes", wr_cnt - w0, 3);
    chk("mid_iter_count", int'(iteration_count), 1);
    chk("mid_monitor", mon_bad - b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
